// File: rtl/ahmes_mem_ctrl.sv
// ahmes_mem_ctrl: REM/RDM memory interface sequencing single-byte RAM reads and writes on a req/done handshake.
// Optional write-verify read-back enabled by defining AHMES_MEM_VERIFY_EN.
module ahmes_mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [ADDR_W-1:0] rem,
    output logic [DATA_W-1:0] rdm,
    output logic              verify_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("ahmes_mem_ctrl: RD_LAT must be within 1..4");
    end

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE, VRD, VCMP} state_t;

    localparam logic [2:0] LAST = 3'(RD_LAT - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] wdata;

    assign mem_addr    = rem;
    assign mem_data_in = wdata;

`ifdef AHMES_MEM_VERIFY_EN
    logic verr;
    assign verify_err = verr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) verr <= 1'b0;
        else if (state == VCMP && mem_data_out != wdata) verr <= 1'b1;
    end
`else
    assign verify_err = 1'b0;
`endif

    // Outputs are registered: each default below is overridden on the edge entering the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            rdm       <= '0;
            wdata     <= '0;
            cnt       <= '0;
            mem_wr_en <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_ready <= 1'b1;
        end else begin
            mem_wr_en <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        rem       <= cpu_addr;
                        wdata     <= cpu_wdata;
                        cnt       <= '0;
                        mem_wr_en <= cpu_we;
                        state     <= cpu_we ? WR : RD;
                    end else begin
                        cpu_ready <= 1'b1;
                    end
                end
`ifdef AHMES_MEM_VERIFY_EN
                WR: state <= VRD;
                VRD: begin
                    cnt   <= cnt + 3'd1;
                    state <= (cnt == LAST) ? VCMP : VRD;
                end
                VCMP: begin
                    state    <= DONE;
                    cpu_done <= 1'b1;
                end
`else
                WR: begin
                    state    <= DONE;
                    cpu_done <= 1'b1;
                end
`endif
                RD: begin
                    cnt   <= cnt + 3'd1;
                    state <= (cnt == LAST) ? CAP : RD;
                end
                CAP: begin
                    rdm      <= mem_data_out;
                    state    <= DONE;
                    cpu_done <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahmes_mem_ctrl.sv
// tb_ahmes_mem_ctrl: randomized scoreboard bench for ahmes_mem_ctrl with a behavioural RAM and reference memory.
module tb_ahmes_mem_ctrl;
    localparam int RD_LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_ready, cpu_done, verify_err, mem_wr_en;
    logic [7:0] rem, rdm, mem_addr, mem_data_in, mem_data_out;

    ahmes_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .rem(rem), .rdm(rdm),
        .verify_err(verify_err), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with bit 0 stuck at zero when the verify feature is built in
    logic [7:0] ram [256];
    logic [7:0] pipe [RD_LAT];
    logic [7:0] wr_val;
`ifdef AHMES_MEM_VERIFY_EN
    assign wr_val = mem_data_in & 8'hFE;
`else
    assign wr_val = mem_data_in;
`endif
    assign mem_data_out = pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (mem_wr_en) begin
            ram[mem_addr] <= wr_val;
        end
        pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } op_t;
    typedef struct { logic we; logic [7:0] addr; logic [7:0] data; int acc; logic [7:0] exp_rd; } txn_t;

    op_t        plan [$];
    txn_t       sb [$];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rdm = 8'h00;
    logic       exp_verr = 1'b0;
    int         ops_left = 0;
    int         wr_pulses = 0;
    bit         hold = 1'b0;
    int         n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input logic we);
`ifdef AHMES_MEM_VERIFY_EN
        return we ? RD_LAT + 3 : RD_LAT + 2;
`else
        return we ? 2 : RD_LAT + 2;
`endif
    endfunction

    task automatic add(input logic we, input logic [7:0] a, input logic [7:0] d);
        plan.push_back('{we, a, d});
        ops_left++;
    endtask

    task automatic drain();
        int n = 0;
        while (ops_left != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(ops_left), 32'd0);
    endtask

    // Driver: presents planned ops when ready, random noise (possibly req pulses) while busy
    initial begin
        op_t op;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                cpu_req = 1'b0;
            end else if (cpu_ready && plan.size() > 0 && (hold || $urandom_range(0, 2) != 0)) begin
                op = plan.pop_front();
                cpu_req = 1'b1; cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.data;
            end else begin
                cpu_req   = !cpu_ready && (hold || $urandom_range(0, 1) == 1);
                cpu_we    = 1'($urandom);
                cpu_addr  = 8'($urandom);
                cpu_wdata = 8'($urandom);
            end
        end
    end

    // Accept monitor: records the transaction and its expected read data
    always @(posedge clk) begin
        if (!rst && cpu_ready && cpu_req)
            sb.push_back('{cpu_we, cpu_addr, cpu_wdata, cyc, ref_mem[cpu_addr]});
    end

    // Output monitor: RAM-side writes and completion pulses
    always @(negedge clk) begin
        txn_t t;
        if (!rst) begin
            chk("mem_addr_eq_rem", mem_addr, rem);
            if (mem_wr_en) begin
                wr_pulses++;
                if (sb.size() == 0 || !sb[0].we) begin
                    chk("spurious_wr_en", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", mem_addr, sb[0].addr);
                    chk("wr_data", mem_data_in, sb[0].data);
                end
            end
            if (cpu_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    t = sb.pop_front();
                    ops_left--;
                    chk("latency", 32'(cyc - t.acc), 32'(lat(t.we)));
                    chk("wr_pulses", 32'(wr_pulses), t.we ? 32'd1 : 32'd0);
                    wr_pulses = 0;
                    if (t.we) begin
`ifdef AHMES_MEM_VERIFY_EN
                        ref_mem[t.addr] = t.data & 8'hFE;
                        exp_verr = exp_verr | t.data[0];
`else
                        ref_mem[t.addr] = t.data;
`endif
                    end else begin
                        last_rdm = t.exp_rd;
                    end
                    chk("rem", rem, t.addr);
                    chk("rdm", rdm, last_rdm);
                    chk("verify_err", verify_err, exp_verr);
                    chk("ready_in_done", cpu_ready, 1'b0);
                end
            end
        end
    end

    initial begin
        logic [7:0] a, d;
        bit seen;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", cpu_ready, 1'b1);
        chk("rst_done", cpu_done, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_rem", rem, 8'h00);
        chk("rst_rdm", rdm, 8'h00);
        chk("rst_verr", verify_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cpu_ready, 1'b1);

        add(1'b1, 8'd20, 8'h54);
        add(1'b1, 8'd10, 8'hAB);
        add(1'b0, 8'd10, 8'h00);
        drain();

        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            add(1'b1, a, d);
            add(1'b0, a, 8'h00);
        end
        add(1'b1, 8'hFF, 8'h5A);
        add(1'b0, 8'hFF, 8'h00);
        add(1'b0, 8'h00, 8'h00);
        drain();
        hold = 1'b0;

        for (int i = 0; i < 24; i++) add(1'($urandom), 8'($urandom), 8'($urandom));
        drain();

        add(1'b1, 8'd21, 8'h55);
        drain();

        // Abort a write by asserting reset inside its WR cycle
        add(1'b1, 8'h77, ~ref_mem[8'h77]);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_wr_en;
        end
        chk("abort_wr_seen", seen, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_wr_en", mem_wr_en, 1'b0);
        chk("abort_ready", cpu_ready, 1'b1);
        chk("abort_done", cpu_done, 1'b0);
        chk("abort_rem", rem, 8'h00);
        chk("abort_rdm", rdm, 8'h00);
        chk("abort_verr", verify_err, 1'b0);
        sb.delete();
        plan.delete();
        ops_left = 0;
        wr_pulses = 0;
        last_rdm = 8'h00;
        exp_verr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        add(1'b0, 8'h77, 8'h00);
        add(1'b0, 8'd10, 8'h00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahmes_mem_ctrl.md
Name: ahmes_mem_ctrl

Overview:
Memory interface unit between the Ahmes control unit and the 8-bit synchronous RAM (memoria_ram: clk, wr_en, address, data_in, data_out; write on clock edge, registered read).
- Holds the REM (address register) and RDM (data register).
- Sequences single-byte read/write transactions on a req/done handshake.
- Hides RAM read latency from the CPU control FSM.

Parameters:
ADDR_W, 8, address width (REM, mem_addr)
DATA_W, 8, data width (RDM, write data, RAM data)
RD_LAT, 1, RAM read latency in cycles; legal range 1..4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cpu_req  input  1  transaction request; sampled only when cpu_ready=1
cpu_we  input  1  1=write, 0=read; sampled with cpu_req
cpu_addr  input  ADDR_W  transaction address; sampled with cpu_req
cpu_wdata  input  DATA_W  write data; sampled with cpu_req
cpu_ready  output  1  high in IDLE only
cpu_done  output  1  one-cycle completion pulse
rem  output  ADDR_W  REM contents
rdm  output  DATA_W  RDM contents (last read data)
verify_err  output  1  sticky write-verify failure flag (see Optional Feature)
mem_addr  output  ADDR_W  to RAM address; always equals rem
mem_wr_en  output  1  to RAM wr_en
mem_data_in  output  DATA_W  to RAM data_in; internal write-data register
mem_data_out  input  DATA_W  from RAM data_out

Behaviour:
- Reset (async, immediate): state=IDLE, rem=0, rdm=0, write-data reg=0, latency counter=0, mem_wr_en=0, cpu_done=0, verify_err=0, cpu_ready=1.
- States: IDLE, WR, RD, CAP, DONE (plus VRD, VCMP with the optional feature).
- IDLE:
  - cpu_ready=1.
  - If cpu_req=1 at an edge: rem<=cpu_addr, wdata<=cpu_wdata, we latched, counter<=0.
  - Next state is WR if cpu_we=1, else RD.
- WR:
  - mem_wr_en=1 for exactly this one cycle. mem_addr and mem_data_in are stable from the accept edge.
  - Next state: DONE.
- RD:
  - Counter increments each cycle; stays in RD for RD_LAT cycles, then goes to CAP.
- CAP:
  - rdm<=mem_data_out at the edge ending CAP.
  - Next state: DONE.
- DONE:
  - cpu_done=1 for one cycle; next state IDLE.
  - rdm stays valid and is held until the next read capture. Writes never modify rdm.
- Latency, counted from accept edge to the cycle in which cpu_done is high: write = 2 cycles; read = RD_LAT+2 cycles.
- mem_wr_en is registered (state-decoded from flops), never combinational from cpu_* inputs. It is 0 in all states other than WR.
- cpu_req while cpu_ready=0 is ignored; no queuing. A req held high continuously produces back-to-back transactions, with one IDLE cycle between a DONE and the next accept.
- cpu_* inputs may change freely after the accept edge without affecting the transaction in flight.
- Address arithmetic: none. Full 2^ADDR_W range is accessible with no wrap logic.
- Reset mid-transaction: aborts immediately and mem_wr_en drops asynchronously. If reset asserts before the WR-cycle edge, no RAM write occurs. No cpu_done is issued for the aborted transaction.
- RD_LAT outside 1..4: elaboration error.

Optional Feature:
- Macro: AHMES_MEM_VERIFY_EN.
- Defined: a write continues WR -> VRD (RD_LAT cycles, address unchanged, mem_wr_en=0) -> VCMP -> DONE.
  - In VCMP: if mem_data_out != wdata, set verify_err=1. The flag is sticky until rst.
  - rdm is unchanged by verify.
  - Write latency becomes RD_LAT+3 cycles.
- Not defined: VRD and VCMP do not exist, write latency is 2 cycles, and verify_err is tied to 0.

Test Plan:
- Reset: assert rst mid-clock -> all outputs 0 asynchronously, cpu_ready=1. Deassert -> cpu_ready remains 1.
- Write 0xAB to address 10 (RD_LAT=1): cpu_req=1, cpu_we=1 for one cycle -> mem_wr_en high for exactly one cycle with mem_addr=10, mem_data_in=0xAB. cpu_done pulses 2 cycles after accept; RAM model holds 0xAB at address 10.
- Read address 10: cpu_done pulses 3 cycles after accept with rdm=0xAB and rem=10. Repeat with RD_LAT=3 -> cpu_done at 5 cycles, rdm=0xAB.
- Five random address/data write-then-read pairs with cpu_req held high continuously: each read rdm equals the data written. cpu_req pulses during busy states are ignored, with no extra mem_wr_en.
- Reset during WR: assert rst in the WR cycle before its rising edge -> mem_wr_en falls immediately. A subsequent read of that address returns the prior value (e.g. 0x00), and no cpu_done is issued for the aborted write.
- With AHMES_MEM_VERIFY_EN and a RAM model forcing bit 0 stuck-at-0: write 0x55 -> cpu_done at RD_LAT+3 cycles and verify_err=1, staying 1 until rst. Writing 0x54 leaves verify_err at 0. Without the macro: write latency is 2 cycles and verify_err stays 0.
